led_sequencer: RTL

//  LED pattern sequencer clocked by CLK; consumes divider output o_CLK as step_clk.
//  - Synchronises step_clk, rising-edge detects it, advances one LED pattern step per edge.
//  - Four selectable patterns, pause and direction control.
//  - Drives the board LED bank; emits step/wrap pulses so further stages can chain.

---
 rtl/led_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
//   LED pattern sequencer. The divided clock from the clock divider arrives on
//   step_clk and is treated purely as data: it is synchronised into the CLK
//   domain, rising-edge detected, and every detected edge advances the active
//   pattern by one step (unless paused or a mode change is being taken).
//
//   Patterns (mode): 00 SHIFT rotating one-hot, 01 BOUNCE one-hot ping-pong,
//                    10 BAR fill level, 11 BLINK whole-bank toggle.
//
// Ports
//   CLK       in   1      system clock, posedge
//   RST       in   1      asynchronous active-high reset
//   step_clk  in   1      divided step clock, sampled as data
//   mode      in   2      pattern select
//   dir       in   1      SHIFT/BAR direction (0 toward MSB, 1 toward LSB)
//   pause     in   1      hold pattern, discard steps
//   led       out  LED_W  LED pattern
//   step_out  out  1      one-cycle pulse per accepted step
//   wrap      out  1      one-cycle pulse when the pattern returns to its start
// ---------------------------------------------------------------------------
module led_sequencer #(
    parameter int LED_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             step_clk,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic             step_out,
    output logic             wrap
);

    localparam int LVL_W = $clog2(LED_W + 1);

    localparam logic [LED_W-1:0] LED_LSB = {{(LED_W-1){1'b0}}, 1'b1};
    localparam logic [LED_W-1:0] LED_MSB = {1'b1, {(LED_W-1){1'b0}}};
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LED_W);

    typedef enum logic [1:0] {
        M_SHIFT  = 2'b00,
        M_BOUNCE = 2'b01,
        M_BAR    = 2'b10,
        M_BLINK  = 2'b11
    } mode_t;

    // Bar of 'lvl' lit LEDs, filled from bit 0 (d=0) or from the MSB (d=1).
    function automatic logic [LED_W-1:0] bar_pattern(input logic [LVL_W-1:0] lvl,
                                                    input logic d);
        logic [LED_W-1:0] m;
        m = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (LVL_W'(i) < lvl) begin
                if (d) m[LED_W-1-i] = 1'b1;
                else   m[i]         = 1'b1;
            end
        end
        return m;
    endfunction

    // ---------------- registers ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    mode_t                  r_mode;
    logic                   r_bounce_up;
    logic [LVL_W-1:0]       r_bar_lvl;
    logic [LED_W-1:0]       r_led;
    logic                   r_step_out;
    logic                   r_wrap;

    // ---------------- next-state wires ----------------
    mode_t                  w_mode_nxt;
    logic                   w_bounce_nxt;
    logic [LVL_W-1:0]       w_lvl_nxt;
    logic [LED_W-1:0]       w_led_nxt;
    logic                   w_step_nxt;
    logic                   w_wrap_nxt;

    logic                   w_sync_last;
    logic                   w_step;
    logic                   w_mode_chg;
    logic                   w_acc;
    logic [LVL_W-1:0]       w_lvl_inc;

    assign w_sync_last = r_sync[SYNC_STAGES-1];
    assign w_step      = w_sync_last & ~r_prev;
    assign w_mode_chg  = (mode != r_mode);
    // A mode change swallows any step arriving in the same cycle.
    assign w_acc       = w_step & ~pause & ~w_mode_chg;
    assign w_lvl_inc   = (r_bar_lvl == LVL_MAX) ? '0 : r_bar_lvl + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync      <= '0;
            r_prev      <= 1'b0;
            r_mode      <= M_SHIFT;
            r_bounce_up <= 1'b1;
            r_bar_lvl   <= '0;
            r_led       <= LED_LSB;
            r_step_out  <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], step_clk};
            // Tracks the edge detector even while paused, so edges seen
            // during pause are consumed rather than deferred.
            r_prev      <= w_sync_last;
            r_mode      <= w_mode_nxt;
            r_bounce_up <= w_bounce_nxt;
            r_bar_lvl   <= w_lvl_nxt;
            r_led       <= w_led_nxt;
            r_step_out  <= w_step_nxt;
            r_wrap      <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_bounce_nxt = r_bounce_up;
        w_lvl_nxt    = r_bar_lvl;
        w_led_nxt    = r_led;
        w_step_nxt   = 1'b0;
        w_wrap_nxt   = 1'b0;

        if (w_mode_chg) begin
            // Load the new pattern's starting state.
            w_mode_nxt   = mode_t'(mode);
            w_bounce_nxt = 1'b1;
            w_lvl_nxt    = '0;
            case (mode_t'(mode))
                M_SHIFT:  w_led_nxt = dir ? LED_MSB : LED_LSB;
                M_BOUNCE: w_led_nxt = LED_LSB;
                M_BAR:    w_led_nxt = '0;
                M_BLINK:  w_led_nxt = '0;
            endcase
        end else if (w_acc) begin
            w_step_nxt = 1'b1;
            case (r_mode)
                M_SHIFT: begin
                    if (dir) w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
                    else     w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
                    w_wrap_nxt = (w_led_nxt == (dir ? LED_MSB : LED_LSB));
                end
                M_BOUNCE: begin
                    if (r_bounce_up) begin
                        if (r_led[LED_W-1]) begin
                            w_bounce_nxt = 1'b0;
                            w_led_nxt    = r_led >> 1;
                        end else begin
                            w_led_nxt    = r_led << 1;
                        end
                    end else begin
                        if (r_led[0]) begin
                            w_bounce_nxt = 1'b1;
                            w_led_nxt    = r_led << 1;
                        end else begin
                            w_led_nxt    = r_led >> 1;
                        end
                    end
                    // Only a downward move can land on bit 0.
                    w_wrap_nxt = (w_led_nxt == LED_LSB);
                end
                M_BAR: begin
                    w_lvl_nxt  = w_lvl_inc;
                    w_led_nxt  = bar_pattern(w_lvl_inc, dir);
                    w_wrap_nxt = (r_bar_lvl == LVL_MAX);
                end
                M_BLINK: begin
                    w_led_nxt  = ~r_led;
                    w_wrap_nxt = (r_led == '1);
                end
            endcase
        end
    end

    assign led      = r_led;
    assign step_out = r_step_out;
    assign wrap     = r_wrap;

endmodule
